// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the single-port memory arbiter.
package mem_arb_pkg;

    localparam int LAT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

endpackage

// File: rtl/mem_lat_cnt.sv
// Loadable saturating counter with a zero flag; UP selects the count direction.
module mem_lat_cnt
    import mem_arb_pkg::*;
#(
    parameter bit UP = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic                 load,
    input  logic [LAT_CNT_W-1:0] load_val,
    input  logic                 step,
    output logic [LAT_CNT_W-1:0] cnt,
    output logic                 zero
);

    logic at_limit_s;

    // Saturate at the end of the range instead of wrapping.
    always_comb begin
        zero       = (cnt == {LAT_CNT_W{1'b0}});
        at_limit_s = UP ? (cnt == {LAT_CNT_W{1'b1}}) : zero;
    end

    // Counter register: load has priority over stepping.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            cnt <= {LAT_CNT_W{1'b0}};
        end else if (load) begin
            cnt <= load_val;
        end else if (step && !at_limit_s) begin
            cnt <= UP ? (cnt + LAT_CNT_W'(1)) : (cnt - LAT_CNT_W'(1));
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Arbiter granting one shared memory port to the I-refill and data paths,
// with fixed-latency tracking, starvation guard and instruction abort.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_abort,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    arb_state_t            state_r, next_state_s;
    req_id_t               id_r;
    logic [ADDR_W-1:0]     addr_r;
    logic [DATA_W-1:0]     wdata_r;
    logic                  we_r, abort_r;
    logic                  i_eff_s, starve_hit_s, grant_i_s, grant_d_s;
    logic                  resp_i_s, resp_d_s;
    logic [LAT_CNT_W-1:0]  lat_cnt_s, starve_cnt_s;
    logic                  lat_zero_s, starve_zero_s;

    // Arbitration in IDLE: data wins unless the instruction side has been starved.
    always_comb begin
        i_eff_s      = i_req && !i_abort;
        starve_hit_s = (starve_cnt_s == LAT_CNT_W'(STARVE_MAX));
        grant_i_s    = (state_r == IDLE) && i_eff_s && (!d_req || starve_hit_s);
        grant_d_s    = (state_r == IDLE) && d_req && !grant_i_s;
    end

    mem_lat_cnt #(.UP(1'b0)) u_lat_cnt (
        .clk      (clk),
        .rst_     (rst_),
        .load     (state_r == ISSUE),
        .load_val (LAT_CNT_W'(MEM_LAT - 1)),
        .step     (state_r == WAIT),
        .cnt      (lat_cnt_s),
        .zero     (lat_zero_s)
    );

    mem_lat_cnt #(.UP(1'b1)) u_starve_cnt (
        .clk      (clk),
        .rst_     (rst_),
        .load     (grant_i_s || (grant_d_s && !i_eff_s && !starve_zero_s)),
        .load_val ({LAT_CNT_W{1'b0}}),
        .step     (grant_d_s && i_eff_s),
        .cnt      (starve_cnt_s),
        .zero     (starve_zero_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; WAIT exits when the count is about to reach zero.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_i_s || grant_d_s) next_state_s = ISSUE;
                else                        next_state_s = IDLE;
            end
            ISSUE: begin
                if (MEM_LAT == 1) next_state_s = RESP;
                else              next_state_s = WAIT;
            end
            WAIT: begin
                if (lat_zero_s || (lat_cnt_s == LAT_CNT_W'(1))) next_state_s = RESP;
                else                                            next_state_s = WAIT;
            end
            RESP:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Latch the winning request and track a sticky instruction abort.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            id_r    <= REQ_I;
            addr_r  <= {ADDR_W{1'b0}};
            we_r    <= 1'b0;
            wdata_r <= {DATA_W{1'b0}};
            abort_r <= 1'b0;
        end else begin
            if (grant_i_s) begin
                id_r    <= REQ_I;
                addr_r  <= i_addr;
                we_r    <= 1'b0;
                wdata_r <= {DATA_W{1'b0}};
            end else if (grant_d_s) begin
                id_r    <= REQ_D;
                addr_r  <= d_addr;
                we_r    <= d_we;
                wdata_r <= d_wdata;
            end else begin
                id_r    <= id_r;
                addr_r  <= addr_r;
                we_r    <= we_r;
                wdata_r <= wdata_r;
            end
            if (state_r == RESP) begin
                abort_r <= 1'b0;
            end else if ((state_r != IDLE) && (id_r == REQ_I) && i_abort) begin
                abort_r <= 1'b1;
            end else begin
                abort_r <= abort_r;
            end
        end
    end

    // Output decode from state and latched request fields.
    always_comb begin
        resp_i_s  = (state_r == RESP) && (id_r == REQ_I);
        resp_d_s  = (state_r == RESP) && (id_r == REQ_D);
        busy      = (state_r != IDLE);
        mem_en    = (state_r == ISSUE);
        mem_we    = (state_r == ISSUE) && we_r;
        mem_addr  = addr_r;
        mem_wdata = wdata_r;
        i_ack     = resp_i_s && !abort_r && !i_abort;
        i_rdata   = i_ack ? mem_rdata : {DATA_W{1'b0}};
        d_ack     = resp_d_s;
        d_rdata   = (resp_d_s && !we_r) ? mem_rdata : {DATA_W{1'b0}};
    end

endmodule
